// File: rtl/pingpong_frame_scheduler.sv
// Ping-pong frame store scheduler: fills one bank from the raster source while the
// addressing logic scans the other, then swaps banks and restarts the scan.
module pingpong_frame_scheduler #(
    parameter int addressBitWidth = 17,
    parameter int rowBitWidth     = 11,
    parameter int colBitWidth     = 11,
    parameter int dataWidth       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [rowBitWidth-1:0]     rowMax,
    input  logic [colBitWidth-1:0]     colMax,
    input  logic [dataWidth-1:0]       pixIn,
    input  logic                       pixValid,
    output logic                       pixReady,
    output logic [rowBitWidth-1:0]     scanRowMax,
    output logic [colBitWidth-1:0]     scanColMax,
    output logic                       scanStart,
    output logic                       scanEn,
    input  logic                       scanDone,
    input  logic [addressBitWidth-1:0] scanAddress,
    input  logic                       scanAddressValid,
    input  logic                       outReady,
    output logic [addressBitWidth-1:0] mem0Addr,
    output logic                       mem0We,
    output logic [dataWidth-1:0]       mem0Wdata,
    input  logic [dataWidth-1:0]       mem0Rdata,
    output logic [addressBitWidth-1:0] mem1Addr,
    output logic                       mem1We,
    output logic [dataWidth-1:0]       mem1Wdata,
    input  logic [dataWidth-1:0]       mem1Rdata,
    output logic [dataWidth-1:0]       pixOut,
    output logic                       pixOutValid,
    output logic                       wrBank,
    output logic [7:0]                 frameCount
);

    localparam int prodW = rowBitWidth + colBitWidth;

    typedef enum logic [1:0] {IDLE, START, SCAN, DRAIN} state_t;

    state_t                     state, stateNext;
    logic                       bankFull;
    logic                       rdBank;
    logic [addressBitWidth-1:0] wrAddr;
    logic [rowBitWidth-1:0]     wrRows;
    logic [colBitWidth-1:0]     wrCols;
    logic                       scanDoneQ;
    logic                       vld_p1, pad_p1, sel_p1;

    logic                       accept, firstPix, lastPix, swap;
    logic [rowBitWidth-1:0]     curRows;
    logic [prodW-1:0]           frameLen, wrAddrExt;

    assign pixReady  = !bankFull;
    assign accept    = pixValid & pixReady;
    assign firstPix  = (wrAddr == '0);
    // Row count is only latched on the first pixel, so that pixel must see rowMax directly.
    assign curRows   = firstPix ? rowMax : wrRows;
    assign frameLen  = prodW'(curRows) * prodW'(colMax);
    assign wrAddrExt = prodW'(wrAddr);
    assign lastPix   = accept & (wrAddrExt == frameLen - prodW'(1));
    assign swap      = (state == IDLE) & bankFull;

    // Write side and bank ownership
    always_ff @(posedge clk) begin
        if (rst) begin
            wrAddr     <= '0;
            bankFull   <= 1'b0;
            wrBank     <= 1'b0;
            rdBank     <= 1'b0;
            frameCount <= '0;
            scanRowMax <= '0;
            scanColMax <= '0;
            scanDoneQ  <= 1'b0;
        end else begin
            scanDoneQ <= scanDone;
            if (accept) begin
                if (lastPix) begin
                    wrAddr   <= '0;
                    bankFull <= 1'b1;
                end else begin
                    wrAddr <= wrAddr + 1'b1;
                end
            end
            if (swap) begin
                rdBank     <= wrBank;
                wrBank     <= ~wrBank;
                bankFull   <= 1'b0;
                scanRowMax <= wrRows;
                scanColMax <= wrCols;
            end
            if (state == DRAIN)
                frameCount <= frameCount + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && firstPix) begin
            wrRows <= rowMax;
            wrCols <= colMax;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // A scanDone level already high on SCAN entry is ignored; only a fresh edge ends the scan.
    always_comb begin
        stateNext = state;
        scanStart = 1'b0;
        scanEn    = 1'b0;
        case (state)
            IDLE:  if (bankFull) stateNext = START;
            START: begin
                scanStart = 1'b1;
                stateNext = SCAN;
            end
            SCAN: begin
                scanEn = outReady;
                if (scanDone && !scanDoneQ) stateNext = DRAIN;
            end
            DRAIN: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        mem0Addr  = wrBank ? scanAddress : wrAddr;
        mem0We    = !wrBank & accept;
        mem0Wdata = wrBank ? '0 : pixIn;
        mem1Addr  = wrBank ? wrAddr : scanAddress;
        mem1We    = wrBank & accept;
        mem1Wdata = wrBank ? pixIn : '0;
    end

    // p1: aligned with the 1-cycle synchronous RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            pad_p1 <= 1'b1;
            sel_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state == SCAN) & scanEn;
            pad_p1 <= !scanAddressValid;
            sel_p1 <= rdBank;
        end
    end

    assign pixOutValid = vld_p1;
    assign pixOut      = pad_p1 ? '0 : (sel_p1 ? mem1Rdata : mem0Rdata);

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// Directed bench for pingpong_frame_scheduler with two behavioural synchronous RAM banks.
module tb_pingpong_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] rowMax, colMax;
    logic [7:0]  pixIn;
    logic        pixValid, pixReady;
    logic [10:0] scanRowMax, scanColMax;
    logic        scanStart, scanEn, scanDone;
    logic [16:0] scanAddress;
    logic        scanAddressValid, outReady;
    logic [16:0] mem0Addr, mem1Addr;
    logic        mem0We, mem1We;
    logic [7:0]  mem0Wdata, mem1Wdata, mem0Rdata, mem1Rdata;
    logic [7:0]  pixOut;
    logic        pixOutValid, wrBank;
    logic [7:0]  frameCount;

    logic [7:0]  m0 [0:255];
    logic [7:0]  m1 [0:255];

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    pingpong_frame_scheduler dut (
        .clk(clk), .rst(rst), .rowMax(rowMax), .colMax(colMax),
        .pixIn(pixIn), .pixValid(pixValid), .pixReady(pixReady),
        .scanRowMax(scanRowMax), .scanColMax(scanColMax),
        .scanStart(scanStart), .scanEn(scanEn), .scanDone(scanDone),
        .scanAddress(scanAddress), .scanAddressValid(scanAddressValid),
        .outReady(outReady),
        .mem0Addr(mem0Addr), .mem0We(mem0We), .mem0Wdata(mem0Wdata), .mem0Rdata(mem0Rdata),
        .mem1Addr(mem1Addr), .mem1We(mem1We), .mem1Wdata(mem1Wdata), .mem1Rdata(mem1Rdata),
        .pixOut(pixOut), .pixOutValid(pixOutValid), .wrBank(wrBank), .frameCount(frameCount)
    );

    always @(posedge clk) begin
        if (mem0We) m0[mem0Addr[7:0]] <= mem0Wdata;
        if (mem1We) m1[mem1Addr[7:0]] <= mem1Wdata;
        mem0Rdata <= m0[mem0Addr[7:0]];
        mem1Rdata <= m1[mem1Addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m0[i] = 8'd0;
            m1[i] = 8'd0;
        end
        rst = 1'b1; rowMax = 11'd4; colMax = 11'd4; pixIn = 8'd0; pixValid = 1'b0;
        scanDone = 1'b0; scanAddress = '0; scanAddressValid = 1'b0; outReady = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check("rst_pixReady", pixReady, 1);
        check("rst_wrBank", wrBank, 0);
        check("rst_frameCount", frameCount, 0);
        check("rst_scanStart", scanStart, 0);
        check("rst_scanEn", scanEn, 0);
        check("rst_pixOutValid", pixOutValid, 0);
        check("rst_pixOut", pixOut, 0);

        // Frame 1: 4x4 into bank0
        for (int i = 1; i <= 16; i++) begin
            pixValid = 1'b1; pixIn = 8'(i);
            #1;
            if (i == 1 || i == 16) begin
                check("f1_mem0We", mem0We, 1);
                check("f1_mem0Addr", mem0Addr, i - 1);
                check("f1_mem1We", mem1We, 0);
            end
            cyc();
        end
        pixValid = 1'b0;
        check("f1_pixReady_low", pixReady, 0);
        check("f1_wrBank_pre", wrBank, 0);
        check("f1_noStartYet", scanStart, 0);
        cyc();
        check("f1_scanStart", scanStart, 1);
        check("f1_wrBank", wrBank, 1);
        check("f1_scanRowMax", scanRowMax, 4);
        check("f1_scanColMax", scanColMax, 4);
        check("f1_pixReady_back", pixReady, 1);
        check("f1_mem0_0", m0[0], 1);
        check("f1_mem0_15", m0[15], 16);
        cyc();
        check("scan_startPulse", scanStart, 0);
        check("scan_en", scanEn, 1);

        // Scan addresses 0..7 with toggling validity while frame 2 fills bank1
        for (int k = 0; k < 8; k++) begin
            scanAddress = 17'(k); scanAddressValid = (k % 2 == 0);
            pixValid = 1'b1; pixIn = 8'(101 + k);
            #1;
            check("f2_mem1We", mem1We, 1);
            check("f2_mem1Addr", mem1Addr, k);
            if (k == 0) check("f2_mem0We", mem0We, 0);
            cyc();
            check("scan_valid", pixOutValid, 1);
            check("scan_pixOut", pixOut, (k % 2 == 0) ? k + 1 : 0);
        end

        // outReady low for 10 cycles; remaining frame-2 pixels continue
        for (int k = 0; k < 10; k++) begin
            outReady = 1'b0;
            pixValid = (k < 8); pixIn = 8'(109 + k);
            scanAddress = 17'd8; scanAddressValid = 1'b1;
            #1;
            check("stall_scanEn", scanEn, 0);
            cyc();
            check("stall_valid", pixOutValid, 0);
        end
        check("f2_pixReady_held", pixReady, 0);

        outReady = 1'b1; pixValid = 1'b1; pixIn = 8'd200;
        #1;
        check("full_noWrite", mem1We, 0);
        check("resume_scanEn", scanEn, 1);
        pixValid = 1'b0;
        cyc();
        check("resume_valid", pixOutValid, 1);
        check("resume_pixOut", pixOut, 9);

        scanDone = 1'b1;
        cyc();
        check("drain_scanEn", scanEn, 0);
        check("drain_count", frameCount, 0);
        cyc();
        check("idle_count", frameCount, 1);
        check("idle_pixReady", pixReady, 0);
        cyc();
        check("sw2_scanStart", scanStart, 1);
        check("sw2_wrBank", wrBank, 0);
        check("sw2_pixReady", pixReady, 1);
        check("f2_mem1_0", m1[0], 101);
        check("f2_mem1_15", m1[15], 116);
        check("f2_mem0_keep", m0[15], 16);
        cyc();
        // scanDone still high from the previous frame: not a new edge
        scanAddress = 17'd3; scanAddressValid = 1'b1;
        cyc();
        check("rd1_pixOut", pixOut, 104);
        check("rd1_valid", pixOutValid, 1);
        cyc(); cyc();
        check("stale_done_scanEn", scanEn, 1);

        // Frame 3: 2x2 into bank0, last pixel lands in DRAIN
        rowMax = 11'd2; colMax = 11'd2;
        for (int k = 0; k < 3; k++) begin
            pixValid = 1'b1; pixIn = 8'(31 + k);
            cyc();
        end
        pixValid = 1'b0; scanDone = 1'b0;
        cyc();
        scanDone = 1'b1;
        cyc();
        check("f3_drain_scanEn", scanEn, 0);
        pixValid = 1'b1; pixIn = 8'd34;
        #1;
        check("f3_last_we", mem0We, 1);
        check("f3_last_addr", mem0Addr, 3);
        cyc();
        pixValid = 1'b0;
        check("f3_count", frameCount, 2);
        check("f3_pixReady", pixReady, 0);
        cyc();
        check("f3_scanStart", scanStart, 1);
        check("f3_wrBank", wrBank, 1);
        check("f3_scanRowMax", scanRowMax, 2);
        check("f3_mem0_3", m0[3], 34);
        cyc();

        // Frame 4: 7 pixels, then reset mid-scan
        rowMax = 11'd4; colMax = 11'd4;
        for (int k = 0; k < 7; k++) begin
            pixValid = 1'b1; pixIn = 8'(51 + k);
            cyc();
        end
        pixValid = 1'b0; pixIn = 8'd0; rst = 1'b1;
        scanAddress = '0; scanAddressValid = 1'b0; scanDone = 1'b0;
        cyc();
        check("mrst_pixReady", pixReady, 1);
        check("mrst_wrBank", wrBank, 0);
        check("mrst_frameCount", frameCount, 0);
        check("mrst_scanEn", scanEn, 0);
        check("mrst_scanStart", scanStart, 0);
        check("mrst_valid", pixOutValid, 0);
        check("mrst_pixOut", pixOut, 0);
        check("mrst_scanRowMax", scanRowMax, 0);
        check("mrst_mem1We", mem1We, 0);
        rst = 1'b0;
        cyc();
        pixValid = 1'b1; pixIn = 8'd77;
        #1;
        check("mrst_wrAddr0", mem0Addr, 0);
        check("mrst_we", mem0We, 1);
        cyc();
        pixValid = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
